// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state type,
// opcode/funct constants, ALU control codes and mux select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class chosen by the FSM; NONE yields a zero control word
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's ALU operation class and the R-type funct
// field to a 3-bit ALU control word, and flags whether funct is supported.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_funct_legal
);

  logic [2:0] w_funct_ctrl;

  // Decode funct into an ALU code and a legality flag
  always_comb begin
    w_funct_ctrl  = ALU_AND;
    o_funct_legal = 1'b1;
    case (i_funct)
      FN_ADD:  w_funct_ctrl = ALU_ADD;
      FN_SUB:  w_funct_ctrl = ALU_SUB;
      FN_AND:  w_funct_ctrl = ALU_AND;
      FN_OR:   w_funct_ctrl = ALU_OR;
      FN_SLT:  w_funct_ctrl = ALU_SLT;
      default: o_funct_legal = 1'b0;
    endcase
  end

  // Select the final control word from the operation class
  always_comb begin
    o_alucontrol = 3'b000;
    case (i_aluop)
      ALUOP_ADD:   o_alucontrol = ALU_ADD;
      ALUOP_SUB:   o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: o_alucontrol = w_funct_ctrl;
      default:     o_alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath.
// Memory handshake: an access is in flight while mem_req=1 and completes
// on the cycle mem_ready=1; until then every output holds and the one-shot
// strobes (irwrite, PC increment, instr_done on a store) stay low.
// mem_ready is ignored whenever mem_req=0.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       halted
);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] w_aluop;
  logic [2:0] w_alu_ctrl;
  logic       w_funct_legal;
  logic       w_pcwrite;
  logic       w_branch;

  mc_aludec u_aludec (
    .i_aluop       (w_aluop),
    .i_funct       (funct),
    .o_alucontrol  (w_alu_ctrl),
    .o_funct_legal (w_funct_legal)
  );

  // State register, asynchronously forced to FETCH by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = w_funct_legal ? S_EXECUTE : S_HALT;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_HALT;
        endcase
      end
      S_MEMADR:  w_next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWB:   w_next_state = S_FETCH;
      S_MEMWR:   if (mem_ready) w_next_state = S_FETCH;
      S_EXECUTE: w_next_state = S_ALUWB;
      S_ALUWB:   w_next_state = S_FETCH;
      S_BRANCH:  w_next_state = S_FETCH;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      S_ADDIWB:  w_next_state = S_FETCH;
      S_JUMP:    w_next_state = S_FETCH;
      S_HALT:    w_next_state = S_HALT;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Output decode per state; everything is masked to zero while reset is high
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcsrc      = PCSRC_ALU;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    w_aluop    = ALUOP_NONE;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = SRCB_FOUR;
        w_aluop   = ALUOP_ADD;
        irwrite   = mem_ready;
        w_pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        w_aluop = ALUOP_ADD;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        w_aluop = ALUOP_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        w_aluop    = ALUOP_SUB;
        pcsrc      = PCSRC_ALUOUT;
        w_branch   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        w_aluop = ALUOP_ADD;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = PCSRC_JUMP;
        w_pcwrite  = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    pcen       = w_pcwrite | (w_branch & zero);
    alucontrol = w_alu_ctrl;
    if (reset) begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = 3'b000;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is
// expanded into its list of datapath steps (what the datapath must do in
// each step, from the instruction's meaning), and every cycle's outputs
// are compared against the step being executed, with memory wait cycles
// inserted at random.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, memwrite, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regdst, memtoreg, regwrite, instr_done, halted;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       halted;
  } out_t;

  typedef struct packed {
    out_t       o;
    logic       is_mem;
    logic       is_branch;
    logic [4:0] reps;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         exp_cyc;
  } vec_t;

  out_t  dut_out;
  step_t plan_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  assign dut_out = {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca,
                    alusrcb, alucontrol, regdst, memtoreg, regwrite,
                    instr_done, halted};

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .instr_done (instr_done),
    .halted     (halted)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check_out(input string nm, input out_t e);
    n_cmp++;
    if (dut_out !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: outputs got %h required %h", nm, $time, dut_out, e);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d required %0d", nm, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  function automatic bit ref_legal_funct(input logic [5:0] fn);
    return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
           fn == 6'b100101 || fn == 6'b101010;
  endfunction

  function automatic out_t fetch_out();
    out_t o = '0;
    o.mem_req = 1'b1; o.irwrite = 1'b1; o.pcen = 1'b1;
    o.alusrcb = 2'b01; o.alucontrol = 3'b010;
    return o;
  endfunction

  task automatic push(input out_t o, input logic m, input logic b, input int reps);
    step_t s;
    s.o = o; s.is_mem = m; s.is_branch = b; s.reps = 5'(reps);
    plan_q.push_back(s);
  endtask

  // Expand one instruction into the datapath steps it requires
  task automatic build_plan(input logic [5:0] iop, input logic [5:0] ifn);
    out_t o;
    plan_q.delete();
    push(fetch_out(), 1'b1, 1'b0, 1);
    o = '0; o.alusrcb = 2'b11; o.alucontrol = 3'b010;                 // branch target
    push(o, 1'b0, 1'b0, 1);
    if (iop == 6'b100011 || iop == 6'b101011) begin
      o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; // address
      push(o, 1'b0, 1'b0, 1);
      if (iop == 6'b100011) begin
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1;                       // read data
        push(o, 1'b1, 1'b0, 1);
        o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1; o.instr_done = 1'b1; // rt <- mem
        push(o, 1'b0, 1'b0, 1);
      end else begin
        o = '0; o.mem_req = 1'b1; o.memwrite = 1'b1; o.iord = 1'b1; o.instr_done = 1'b1;
        push(o, 1'b1, 1'b0, 1);
      end
    end else if (iop == 6'b000000 && ref_legal_funct(ifn)) begin
      o = '0; o.alusrca = 1'b1; o.alucontrol = ref_alu(ifn);           // A op B
      push(o, 1'b0, 1'b0, 1);
      o = '0; o.regdst = 1'b1; o.regwrite = 1'b1; o.instr_done = 1'b1; // rd <- result
      push(o, 1'b0, 1'b0, 1);
    end else if (iop == 6'b000100) begin
      o = '0; o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.instr_done = 1'b1;
      push(o, 1'b0, 1'b1, 1);
    end else if (iop == 6'b001000) begin
      o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010;
      push(o, 1'b0, 1'b0, 1);
      o = '0; o.regwrite = 1'b1; o.instr_done = 1'b1;                   // rt <- sum
      push(o, 1'b0, 1'b0, 1);
    end else if (iop == 6'b000010) begin
      o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1; o.instr_done = 1'b1;
      push(o, 1'b0, 1'b0, 1);
    end else begin
      o = '0; o.halted = 1'b1;                                         // stuck until reset
      push(o, 1'b0, 1'b0, 20);
    end
  endtask

  function automatic int pick(input int w);
    return (w < 0) ? int'($urandom_range(0, 3)) : w;
  endfunction

  // Run one instruction cycle by cycle. fw/dw = wait cycles on the fetch /
  // data access (-1 = random). abort_at >= 0 stops after two wait cycles
  // of that step.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                           input int fw, input int dw, input int abort_at,
                           output int cyc, output int dones, output int mw);
    step_t st;
    out_t  e;
    int    w, n;
    build_plan(iop, ifn);
    op = iop; funct = ifn;
    cyc = 0; dones = 0; mw = 0;
    for (int k = 0; k < plan_q.size(); k++) begin
      st = plan_q[k];
      w  = 0;
      if (st.is_mem) w = (k == 0) ? pick(fw) : pick(dw);
      if (k == abort_at) w = 2;
      n = st.is_mem ? w + 1 : int'(st.reps);
      if (k == abort_at) n = 2;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (st.is_mem) mem_ready = (c == w);
        else           mem_ready = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        #1;
        e = st.o;
        if (st.is_branch) e.pcen = zero;
        if (st.is_mem && c != w) begin
          e.irwrite = 1'b0; e.pcen = 1'b0; e.instr_done = 1'b0;
        end
        check_out("step", e);
        cyc++;
        if (instr_done) dones++;
        if (memwrite) mw++;
      end
      if (k == abort_at) return;
    end
  endtask

  // Pulse reset at a negedge; outputs must clear at once, then come back as
  // a FETCH that is still waiting for memory
  task automatic reset_check(input string nm);
    out_t e;
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1 check_out({nm, "_async_zero"}, '0);
    @(negedge clk);
    #1 check_out({nm, "_held_zero"}, '0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    e = fetch_out(); e.irwrite = 1'b0; e.pcen = 1'b0;
    check_out({nm, "_fetch_after"}, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t vecs[10];
    logic [5:0] legal_fn[5];
    logic [5:0] ops[6];
    int cyc, dones, mw, tot_dones, tot_cyc, i_cyc;
    logic [5:0] rop, rfn;

    vecs[0] = '{6'b100011, 6'b000000, 5};
    vecs[1] = '{6'b101011, 6'b000000, 4};
    vecs[2] = '{6'b000000, 6'b100000, 4};
    vecs[3] = '{6'b000000, 6'b100010, 4};
    vecs[4] = '{6'b000000, 6'b100100, 4};
    vecs[5] = '{6'b000000, 6'b100101, 4};
    vecs[6] = '{6'b000000, 6'b101010, 4};
    vecs[7] = '{6'b001000, 6'b010101, 4};
    vecs[8] = '{6'b000100, 6'b000000, 3};
    vecs[9] = '{6'b000010, 6'b111111, 3};
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    // Reset
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_out("reset_zero", '0);
    reset = 1'b0;
    #1 check_out("first_fetch", '{mem_req:1'b1, alusrcb:2'b01, alucontrol:3'b010, default:'0});

    // Table: zero-wait cycle counts, one retire each
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fn, 0, 0, -1, cyc, dones, mw);
      check_int("tbl_cycles", cyc, vecs[i].exp_cyc);
      check_int("tbl_done", dones, 1);
    end

    // SW with three wait cycles in the write
    run_instr(6'b101011, 6'b0, 0, 3, -1, cyc, dones, mw);
    check_int("sw_wait_cycles", cyc, 7);
    check_int("sw_wait_memwrite", mw, 4);
    check_int("sw_wait_done", dones, 1);

    // addi, add, j
    tot_dones = 0; tot_cyc = 0;
    run_instr(6'b001000, 6'b0, 0, 0, -1, cyc, dones, mw);
    check_int("seq_addi", cyc, 4); tot_dones += dones;
    run_instr(6'b000000, 6'b100000, 0, 0, -1, cyc, dones, mw);
    check_int("seq_add", cyc, 4); tot_dones += dones;
    run_instr(6'b000010, 6'b0, 0, 0, -1, cyc, dones, mw);
    check_int("seq_j", cyc, 3); tot_dones += dones;
    check_int("seq_dones", tot_dones, 3);

    // Illegal opcode and illegal funct both halt, never retire
    run_instr(6'b111111, 6'b0, 0, 0, -1, cyc, dones, mw);
    check_int("halt_op_done", dones, 0);
    reset_check("halt_op");
    run_instr(6'b000000, 6'b100111, -1, 0, -1, cyc, dones, mw);
    check_int("halt_fn_done", dones, 0);
    reset_check("halt_fn");

    // Reset while LW is waiting in its data read
    run_instr(6'b100011, 6'b0, 0, 0, 3, cyc, dones, mw);
    check_int("abort_no_done", dones, 0);
    reset_check("abort_memrd");

    // Random legal instruction stream with random wait states
    tot_dones = 0; tot_cyc = 0;
    for (int n = 0; n < 300; n++) begin
      rop = ops[$urandom_range(0, 5)];
      rfn = (rop == 6'b000000) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(rop, rfn, -1, -1, -1, i_cyc, dones, mw);
      tot_dones += dones;
      tot_cyc += i_cyc;
    end
    check_int("rand_dones", tot_dones, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences a shared-memory, multicycle MIPS datapath: one instruction runs as 3–5 state steps instead of one combinational decode. It drives the mux selects, write enables and ALU control for one non-architectural instruction register, one PC register and one unified memory port. It adds a req/ready memory handshake, so wait-state memories are supported. It also adds a sticky halt on illegal instructions and a retire pulse for performance counting.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- memwrite  out  1  write strobe; only asserted together with mem_req
- irwrite  out  1  load instruction register
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- pcsrc  out  2  00 = ALU result, 01 = ALU result register (branch target), 10 = jump target
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = register B, 01 = constant 4, 10 = signimm, 11 = signimm<<2
- alucontrol  out  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = data register, 0 = ALU result register
- regwrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction
- halted  out  1  sticky illegal-instruction indicator

## Operation
- States, 4-bit: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite and pcwrite are asserted only when mem_ready=1. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, add (precomputes the branch target). Next state:
  - LW/SW (100011/101011) → MEMADR
  - RTYPE (000000) with legal funct → EXECUTE
  - BEQ (000100) → BRANCH
  - ADDI (001000) → ADDIEX
  - J (000010) → JUMP
  - anything else, including an illegal funct → HALT
- Legal funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- MEMADR: alusrca=1, alusrcb=10, add. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Next state FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Waits for mem_ready. On the mem_ready cycle instr_done=1 and the next state is FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct. Next state ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1, instr_done=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1. Next state FETCH.
- HALT: halted=1 and all other outputs 0. Left only by reset.
- Any output not listed for a state is 0, never x.

## Timing
- Reset: state is forced to FETCH asynchronously. While reset is high every output is 0 (strobes are masked). The first mem_req is asserted in the first cycle after reset deasserts.
- Cycles per instruction with mem_ready tied high: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each wait cycle (mem_req=1, mem_ready=0) adds one cycle.
- During a wait, every output holds its value and no enable fires twice. Exactly one irwrite, one PC increment and one memwrite occur per access.
- mem_ready while mem_req=0 is ignored.
- instr_done fires exactly once per retired instruction. HALT never pulses it.
- Reset in mid-wait or mid-instruction aborts the instruction with no further strobes.

## Structure
- Package mc_pkg holds:
  - state enum type
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALU control constants
  - pcsrc and alusrcb encodings
- One sub-module: mc_aludec, a combinational map of (aluop, funct) to alucontrol plus a funct_legal flag. The FSM supplies aluop.
- State register: a single always_ff with asynchronous reset. Next state and outputs: a single always_comb each.

## Test plan
- LW with mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, 5 cycles. regwrite=1 with memtoreg=1 only in cycle 5; instr_done pulses once.
- SW with mem_ready low for 3 cycles in MEMWR: memwrite held for 4 cycles, state advances only on the ready cycle, total 7 cycles.
- BEQ with zero=1 gives pcen=1 and pcsrc=01 in cycle 3. With zero=0, pcen stays 0 after FETCH.
- Instruction sequence addi, add, j: per-instruction cycle counts 4, 4, 3; exactly three instr_done pulses.
- op=111111: DECODE→HALT, halted=1, all strobes 0 for 20 cycles. Then reset→FETCH with halted=0.
- Reset asserted in MEMRD while waiting: all outputs go 0 immediately. After release the FSM is in FETCH with mem_req=1 and iord=0.
